// File: rtl/mac_accum_multi_pkg.sv
// rtl/mac_accum_multi_pkg.sv - opcodes and default widths shared by the MAC slice
package mac_accum_multi_pkg;

   localparam int MAC_DATA_WIDTH = 16;
   localparam int MAC_ACC_WIDTH  = 24;
   localparam int MAC_FRAC_BITS  = 15;

   typedef enum logic [1:0] {
      MAC_OP_NOP  = 2'b00,
      MAC_OP_LOAD = 2'b01,
      MAC_OP_ACC  = 2'b10,
      MAC_OP_SUB  = 2'b11
   } mac_op_e;

endpackage

// File: rtl/mac_accum_multi_if.sv
// rtl/mac_accum_multi_if.sv - operation request and result bus of the multi-channel MAC
interface mac_accum_multi_if #(
   parameter int DATA_WIDTH = mac_accum_multi_pkg::MAC_DATA_WIDTH,
   parameter int NUM_CH     = 4
);
   import mac_accum_multi_pkg::*;

   localparam int CH_W = $clog2(NUM_CH);

   logic                         clear;
   logic                         in_valid;
   mac_op_e                      op;
   logic [CH_W-1:0]              chan;
   logic signed [DATA_WIDTH-1:0] data_a;
   logic signed [DATA_WIDTH-1:0] data_b;
   logic                         out_valid;
   logic [CH_W-1:0]              out_chan;
   logic signed [DATA_WIDTH-1:0] acc_out;
   logic [NUM_CH-1:0]            sat_flag;

   modport master (
      output clear, in_valid, op, chan, data_a, data_b,
      input  out_valid, out_chan, acc_out, sat_flag
   );

   modport slave (
      input  clear, in_valid, op, chan, data_a, data_b,
      output out_valid, out_chan, acc_out, sat_flag
   );

endinterface

// File: rtl/mac_mult_round.sv
// rtl/mac_mult_round.sv - signed fractional multiply, round-half-up, saturate to ACC_WIDTH
module mac_mult_round #(
   parameter int DATA_WIDTH = mac_accum_multi_pkg::MAC_DATA_WIDTH,
   parameter int FRAC_BITS  = mac_accum_multi_pkg::MAC_FRAC_BITS,
   parameter int ACC_WIDTH  = mac_accum_multi_pkg::MAC_ACC_WIDTH
) (
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  p,
   output logic                         sat
);
   // One guard bit above the full product so the rounding add can never wrap.
   localparam int PW = 2*DATA_WIDTH + 1;
   localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC_BITS-1);

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] rnd;

   always_comb begin
      prod = PW'(a) * PW'(b);
      rnd  = (prod + HALF) >>> FRAC_BITS;
   end

   generate
      if (ACC_WIDTH >= PW) begin : g_extend
         assign p   = ACC_WIDTH'(rnd);
         assign sat = 1'b0;
      end else begin : g_saturate
         localparam logic signed [PW-1:0] ACC_MAX = (PW'(1) <<< (ACC_WIDTH-1)) - PW'(1);
         localparam logic signed [PW-1:0] ACC_MIN = -ACC_MAX - PW'(1);
         always_comb begin
            p   = rnd[ACC_WIDTH-1:0];
            sat = 1'b0;
            if (rnd > ACC_MAX) begin
               p   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
               sat = 1'b1;
            end else if (rnd < ACC_MIN) begin
               p   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
               sat = 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/mac_accum_multi.sv
// rtl/mac_accum_multi.sv - two-stage multi-channel saturating multiply-accumulate unit
module mac_accum_multi
   import mac_accum_multi_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_WIDTH,
   parameter int FRAC_BITS  = MAC_FRAC_BITS,
   parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
   parameter int NUM_CH     = 4
) (
   input  logic clock,
   input  logic reset,
   mac_accum_multi_if.slave bus
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int AW1  = ACC_WIDTH + 1;

   localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] p;
   logic                        psat;
   logic                        chan_ok;

   logic                        s1_valid;
   mac_op_e                     s1_op;
   logic [CH_W-1:0]             s1_chan;
   logic signed [ACC_WIDTH-1:0] s1_p;
   logic                        s1_psat;

   logic signed [ACC_WIDTH-1:0] acc [NUM_CH];

   logic signed [ACC_WIDTH-1:0]  cur;
   logic signed [AW1-1:0]        sum;
   logic                         acc_ovf;
   logic signed [ACC_WIDTH-1:0]  new_acc;
   logic [ACC_WIDTH-DATA_WIDTH:0] high_bits;
   logic                         out_ovf;
   logic signed [DATA_WIDTH-1:0] out_val;
   logic                         sat_hit;

   mac_mult_round #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mult (
      .a   (bus.data_a),
      .b   (bus.data_b),
      .p   (p),
      .sat (psat)
   );

   assign chan_ok = ({1'b0, bus.chan} < (CH_W+1)'(NUM_CH));

   // Read-modify-write of the channel happens entirely here, so back-to-back ops never see stale data.
   always_comb begin
      cur = acc[s1_chan];
      case (s1_op)
         MAC_OP_LOAD: sum = AW1'(s1_p);
         MAC_OP_ACC:  sum = AW1'(cur) + AW1'(s1_p);
         MAC_OP_SUB:  sum = AW1'(cur) - AW1'(s1_p);
         default:     sum = AW1'(cur);
      endcase
      acc_ovf   = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
      new_acc   = acc_ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
      high_bits = new_acc[ACC_WIDTH-1:DATA_WIDTH-1];
      out_ovf   = !((&high_bits) || (~|high_bits));
      out_val   = out_ovf ? (new_acc[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX) : new_acc[DATA_WIDTH-1:0];
      sat_hit   = acc_ovf | out_ovf | (s1_psat & (s1_op != MAC_OP_NOP));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid      <= 1'b0;
         s1_op         <= MAC_OP_NOP;
         s1_chan       <= '0;
         s1_p          <= '0;
         s1_psat       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_chan  <= '0;
         bus.acc_out   <= '0;
         bus.sat_flag  <= '0;
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else if (bus.clear) begin
         s1_valid      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.sat_flag  <= '0;
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else begin
         s1_valid      <= bus.in_valid && chan_ok;
         s1_op         <= bus.op;
         s1_chan       <= bus.chan;
         s1_p          <= p;
         s1_psat       <= psat;
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            acc[s1_chan] <= new_acc;
            bus.out_chan <= s1_chan;
            bus.acc_out  <= out_val;
            if (sat_hit) bus.sat_flag[s1_chan] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_accum_multi.sv
// tb/tb_mac_accum_multi.sv - directed scoreboard bench for mac_accum_multi
module tb_mac_accum_multi;
   import mac_accum_multi_pkg::*;

   typedef struct {
      logic [1:0]  chan;
      logic [15:0] acc;
      logic [3:0]  sat;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q[$];

   mac_accum_multi_if #(.DATA_WIDTH(16), .NUM_CH(4)) bus ();

   mac_accum_multi #(
      .DATA_WIDTH (16),
      .FRAC_BITS  (15),
      .ACC_WIDTH  (24),
      .NUM_CH     (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && bus.out_valid) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got chan %0d acc_out %h, required no output (cycle %0d)",
                     bus.out_chan, bus.acc_out, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_chan", {30'b0, bus.out_chan}, {30'b0, e.chan});
            check("acc_out", {16'b0, bus.acc_out}, {16'b0, e.acc});
            check("sat_flag", {28'b0, bus.sat_flag}, {28'b0, e.sat});
            check("latency", cyc, e.cyc);
         end
      end
   end

   task automatic drive(input logic clr, input logic v, input mac_op_e o, input logic [1:0] c,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic exp_out, input logic [15:0] ea, input logic [3:0] es);
      @(posedge clock);
      #1;
      bus.clear    = clr;
      bus.in_valid = v;
      bus.op       = o;
      bus.chan     = c;
      bus.data_a   = a;
      bus.data_b   = b;
      if (exp_out) q.push_back('{c, ea, es, cyc + 2});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         bus.in_valid = 1'b0;
         bus.clear    = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.op       = MAC_OP_NOP;
      bus.chan     = '0;
      bus.data_a   = '0;
      bus.data_b   = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_acc_out", {16'b0, bus.acc_out}, 32'd0);
      check("rst_out_chan", {30'b0, bus.out_chan}, 32'd0);
      check("rst_sat_flag", {28'b0, bus.sat_flag}, 32'd0);
      reset = 1'b0;

      // LOAD then ACC on ch0, back to back
      drive(0, 1, MAC_OP_LOAD, 0, 16'h4000, 16'h4000, 1, 16'h2000, 4'h0);
      drive(0, 1, MAC_OP_ACC,  0, 16'h4000, 16'h4000, 1, 16'h4000, 4'h0);
      // interleaved loads on ch1/ch2, then readback
      drive(0, 1, MAC_OP_LOAD, 1, 16'h2000, 16'h7FFF, 1, 16'h2000, 4'h0);
      drive(0, 1, MAC_OP_LOAD, 2, 16'hC000, 16'h4000, 1, 16'hE000, 4'h0);
      drive(0, 1, MAC_OP_NOP,  1, 16'h0000, 16'h0000, 1, 16'h2000, 4'h0);
      // ch3 accumulates past the output range and sticks its flag
      drive(0, 1, MAC_OP_ACC,  3, 16'h7FFF, 16'h7FFF, 1, 16'h7FFE, 4'h0);
      drive(0, 1, MAC_OP_ACC,  3, 16'h7FFF, 16'h7FFF, 1, 16'h7FFF, 4'h8);
      drive(0, 1, MAC_OP_ACC,  3, 16'h7FFF, 16'h7FFF, 1, 16'h7FFF, 4'h8);
      drive(0, 1, MAC_OP_SUB,  3, 16'h7FFF, 16'h7FFF, 1, 16'h7FFF, 4'h8);
      // -1 * -1 = +1.0 does not fit the output
      drive(0, 1, MAC_OP_LOAD, 0, 16'h8000, 16'h8000, 1, 16'h7FFF, 4'h9);
      idle(2);
      drive(1, 0, MAC_OP_NOP,  0, 16'h0000, 16'h0000, 0, 16'h0000, 4'h0);
      drive(0, 1, MAC_OP_NOP,  0, 16'h0000, 16'h0000, 1, 16'h0000, 4'h0);
      drive(0, 1, MAC_OP_NOP,  3, 16'h0000, 16'h0000, 1, 16'h0000, 4'h0);
      idle(2);

      // clear while the pipeline is full: in-flight and same-cycle ops vanish
      drive(0, 1, MAC_OP_LOAD, 0, 16'h4000, 16'h4000, 1, 16'h2000, 4'h0);
      drive(0, 1, MAC_OP_LOAD, 1, 16'h4000, 16'h4000, 1, 16'h2000, 4'h0);
      drive(0, 1, MAC_OP_LOAD, 2, 16'h4000, 16'h4000, 0, 16'h0000, 4'h0);
      drive(1, 1, MAC_OP_LOAD, 3, 16'h4000, 16'h4000, 0, 16'h0000, 4'h0);
      idle(3);
      for (int c = 0; c < 4; c++)
         drive(0, 1, MAC_OP_NOP, 2'(c), 16'h0000, 16'h0000, 1, 16'h0000, 4'h0);
      idle(2);

      // asynchronous reset between edges with an op still in flight
      drive(0, 1, MAC_OP_LOAD, 2, 16'h8000, 16'h8000, 1, 16'h7FFF, 4'h4);
      drive(0, 1, MAC_OP_ACC,  2, 16'h4000, 16'h4000, 0, 16'h0000, 4'h0);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      #6;
      reset = 1'b1;
      #1;
      check("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("async_acc_out", {16'b0, bus.acc_out}, 32'd0);
      check("async_out_chan", {30'b0, bus.out_chan}, 32'd0);
      check("async_sat_flag", {28'b0, bus.sat_flag}, 32'd0);
      @(posedge clock);
      #1;
      check("held_out_valid", {31'b0, bus.out_valid}, 32'd0);
      reset = 1'b0;
      idle(1);
      drive(0, 1, MAC_OP_LOAD, 2, 16'h4000, 16'h4000, 1, 16'h2000, 4'h0);
      drive(0, 1, MAC_OP_NOP,  3, 16'h0000, 16'h0000, 1, 16'h0000, 4'h0);
      idle(5);

      check("queue_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
